iir_channel_scheduler: RTL and testbench
========================================

// Module: iir_channel_scheduler
// PURPOSE
//  Time-multiplexes one first-order IIR (de-emphasis) datapath across CHANNELS audio channels.
//  Sits after demodulation, between per-channel input FIFOs and per-channel output FIFOs.
//  Holds each channel's x[n-1]/y[n-1] history and sequences one shared multiplier,
//  doing three multiplies per sample. Channels are served round-robin.
// PARAMETERS
//  DATA_WIDTH  32    sample width, signed, fixed-point with FRAC fraction bits
//  CHANNELS    2     number of channels served (>=1)
//  FRAC        10    fixed-point fraction bits for coefficients/products
//  B0          178   feed-forward coefficient on x[n] (quantized)
//  B1          178   feed-forward coefficient on x[n-1]
//  A1          -666  feedback coefficient on y[n-1]; sign is already folded in, term is added
// PORTS
//  clock        in   1                      system clock
//  reset        in   1                      asynchronous, active-high
//  clear        in   1                      sync: zero all channel histories (only acted on in IDLE)
//  x_in         in   CHANNELS*DATA_WIDTH    per-channel FWFT FIFO data; ch c at [c*DW +: DW]
//  x_in_empty   in   CHANNELS               per-channel input FIFO empty
//  x_in_rd_en   out  CHANNELS               per-channel pop; one-hot or zero
//  y_out        out  CHANNELS*DATA_WIDTH    per-channel result data; same packing as x_in
//  y_out_full   in   CHANNELS               per-channel output FIFO full
//  y_out_wr_en  out  CHANNELS               per-channel push; one-hot or zero
//  busy         out  1                      high in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE, rr=0, all histories=0, accumulator=0.
//   Outputs during reset: rd_en=0, wr_en=0, y_out=0, busy=0.
//  Eligibility: channel c is eligible when !x_in_empty[c] && !y_out_full[c].
//  State machine: IDLE -> READ -> MUL0 -> MUL1 -> MUL2 -> WRITE -> IDLE.
//  IDLE:
//   - If clear=1: zero all histories, stay in IDLE. Clear has priority over selection.
//   - Otherwise scan rr, rr+1, ... (mod CHANNELS) and latch the first eligible channel as sel.
//   - If none is eligible, stay in IDLE.
//  READ: x_in_rd_en[sel]=1 for exactly one cycle. Capture x = x_in[sel] in the same cycle. acc=0.
//  MUL0: acc += DQ(B0*x).
//  MUL1: acc += DQ(B1*xh[sel]).
//  MUL2: acc += DQ(A1*yh[sel]).
//  WRITE:
//   - Wait while y_out_full[sel]=1; this is defensive, because selection already checked full.
//   - On the accepted cycle: y_out_wr_en[sel]=1 and y_out[sel]=acc[DW-1:0].
//   - Same cycle: xh[sel]<=x, yh[sel]<=acc[DW-1:0], rr<=(sel+1)%CHANNELS.
//  Arithmetic:
//   - Each product is signed 2*DW bits.
//   - DQ(p) = (p<0 ? p+(2^FRAC-1) : p) >>> FRAC, i.e. rounds toward zero.
//   - acc is DW+2 bits signed. The result is truncated (wraps) to DW bits with no saturation.
//  Timing: 6 cycles per sample (IDLE..WRITE) with no backpressure.
//   - Aggregate throughput is 1 sample / 6 cycles shared across all channels.
//   - y_out is driven in the cycle 4 cycles after the rd_en cycle.
//  Data outputs:
//   - y_out[c] holds the last written value for channel c. Only wr_en qualifies it.
//   - Non-selected lanes never pulse.
//  Boundaries:
//   - An input emptying after selection is impossible, since only this block pops it.
//   - If every channel is ineligible, the block idles with no strobes.
//   - Reset mid-sample aborts with no write and no history update; histories return to 0.
//   - CHANNELS=1 degenerates to a fixed sequence with rr held at 0.
// TESTING
//  1 ch, zero history, x=1024 -> y=178; then x=1024 -> y=178+178+DQ(-666*178)=356-115=241.
//  x=-1 on zeroed history -> DQ(-178)=0, y=0 (round toward zero; never -1).
//  Both channels hold 3 samples each -> write order ch0,ch1,ch0,ch1,ch0,ch1; per-channel y matches a
//   single-channel model; rd_en/wr_en pulses are never coincident across channels.
//  ch1 y_out_full=1, both inputs non-empty -> only ch0 is served, x_in_rd_en[1] stays 0;
//   drop full -> ch1 is served next.
//  Assert reset during MUL1 -> no wr_en, all outputs 0; after release x=1024 on ch0 -> y=178.
//  Pulse clear in IDLE after history is built up -> next x=1024 gives 178; clear held high blocks
//   all reads.

Source files
------------

// File: rtl/iir_channel_scheduler.sv
// Round-robin time-multiplexed first-order IIR over CHANNELS lanes, one shared multiplier.
// 6 cycles per sample (IDLE,READ,MUL0..2,WRITE); y_out/wr_en 4 cycles after rd_en; WRITE stalls while the lane's output is full.
module iir_channel_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int CHANNELS   = 2,
    parameter int FRAC       = 10,
    parameter int B0         = 178,
    parameter int B1         = 178,
    parameter int A1         = -666
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           clear,
    input  logic [CHANNELS*DATA_WIDTH-1:0] x_in,
    input  logic [CHANNELS-1:0]            x_in_empty,
    output logic [CHANNELS-1:0]            x_in_rd_en,
    output logic [CHANNELS*DATA_WIDTH-1:0] y_out,
    input  logic [CHANNELS-1:0]            y_out_full,
    output logic [CHANNELS-1:0]            y_out_wr_en,
    output logic                           busy
);

    localparam int DW = DATA_WIDTH;
    localparam int AW = DATA_WIDTH + 2;
    localparam int PW = 2 * DATA_WIDTH;
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [2:0] {IDLE, READ, MUL0, MUL1, MUL2, WRITE} state_t;

    state_t                state;
    logic [CW-1:0]         rr;
    logic [CW-1:0]         sel;
    logic signed [DW-1:0]  x_cur;
    logic signed [AW-1:0]  acc;
    logic signed [DW-1:0]  xh     [CHANNELS];
    logic signed [DW-1:0]  yh     [CHANNELS];
    logic signed [DW-1:0]  y_hold [CHANNELS];

    logic [CHANNELS-1:0]   eligible;
    logic                  found;
    logic [CW-1:0]         pick;

    logic signed [DW-1:0]  coef;
    logic signed [DW-1:0]  opnd;
    logic signed [PW-1:0]  prod;
    logic signed [PW-1:0]  prod_adj;
    logic signed [PW-1:0]  dq;
    logic signed [AW-1:0]  term;

    assign eligible = ~x_in_empty & ~y_out_full;

    // First eligible lane starting at the round-robin pointer.
    always_comb begin
        found = 1'b0;
        pick  = rr;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!found && eligible[(int'(rr) + i) % CHANNELS]) begin
                found = 1'b1;
                pick  = CW'((int'(rr) + i) % CHANNELS);
            end
        end
    end

    always_comb begin
        coef = '0;
        opnd = x_cur;
        case (state)
            MUL0: begin coef = DW'(B0); opnd = x_cur;   end
            MUL1: begin coef = DW'(B1); opnd = xh[sel]; end
            MUL2: begin coef = DW'(A1); opnd = yh[sel]; end
            default: ;
        endcase
    end

    // Biasing negative products before the arithmetic shift makes it round toward zero.
    assign prod     = coef * opnd;
    assign prod_adj = prod[PW-1] ? (prod + PW'((2 ** FRAC) - 1)) : prod;
    assign dq       = prod_adj >>> FRAC;
    assign term     = AW'(dq);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rr         <= '0;
            sel        <= '0;
            x_cur      <= '0;
            acc        <= '0;
            x_in_rd_en <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                xh[c]     <= '0;
                yh[c]     <= '0;
                y_hold[c] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (clear) begin
                        for (int c = 0; c < CHANNELS; c++) begin
                            xh[c] <= '0;
                            yh[c] <= '0;
                        end
                    end else if (found) begin
                        sel        <= pick;
                        x_in_rd_en <= CHANNELS'(1) << pick;
                        state      <= READ;
                    end
                end
                READ: begin
                    x_cur      <= x_in[sel*DW +: DW];
                    acc        <= '0;
                    x_in_rd_en <= '0;
                    state      <= MUL0;
                end
                MUL0: begin
                    acc   <= acc + term;
                    state <= MUL1;
                end
                MUL1: begin
                    acc   <= acc + term;
                    state <= MUL2;
                end
                MUL2: begin
                    acc   <= acc + term;
                    state <= WRITE;
                end
                WRITE: begin
                    if (!y_out_full[sel]) begin
                        xh[sel]     <= x_cur;
                        yh[sel]     <= acc[DW-1:0];
                        y_hold[sel] <= acc[DW-1:0];
                        rr          <= (sel == CW'(CHANNELS - 1)) ? '0 : sel + 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Lanes show their last written result; the selected lane shows the live result while writing.
    always_comb begin
        y_out_wr_en = '0;
        y_out       = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            y_out[c*DW +: DW] = y_hold[c];
        end
        if (state == WRITE) begin
            y_out_wr_en[sel]    = !y_out_full[sel];
            y_out[sel*DW +: DW] = acc[DW-1:0];
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_iir_channel_scheduler.sv
// Scoreboarded bench for iir_channel_scheduler: FIFO models feed lanes, expected results queued at each pop.
module tb_iir_channel_scheduler;

    localparam int DW = 32;
    localparam int CH = 2;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               clear = 1'b0;
    logic [CH*DW-1:0]   x_in;
    logic [CH-1:0]      x_in_empty;
    logic [CH-1:0]      x_in_rd_en;
    logic [CH*DW-1:0]   y_out;
    logic [CH-1:0]      y_out_full;
    logic [CH-1:0]      y_out_wr_en;
    logic               busy;

    iir_channel_scheduler #(
        .DATA_WIDTH(DW), .CHANNELS(CH), .FRAC(10), .B0(178), .B1(178), .A1(-666)
    ) dut (
        .clock(clock), .reset(reset), .clear(clear),
        .x_in(x_in), .x_in_empty(x_in_empty), .x_in_rd_en(x_in_rd_en),
        .y_out(y_out), .y_out_full(y_out_full), .y_out_wr_en(y_out_wr_en),
        .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        int ch;
        int x;
        int y;
        int cyc;
    } exp_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   in_data [CH][64];
    int   in_cnt  [CH];
    int   in_rd   [CH];
    int   mxh [CH];
    int   myh [CH];
    exp_t exp_q [$];
    int   log_ch [64];
    int   log_y  [64];
    int   wr_total = 0;
    int   rd_total = 0;
    int   rd_ch_cnt [CH];
    int   cyc = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int dq(input longint p);
        longint r;
        r = (p < 0) ? p + 1023 : p;
        return int'(r >>> 10);
    endfunction

    function automatic int model_y(input int x, input int xh, input int yh);
        return dq(longint'(178) * x) + dq(longint'(178) * xh) + dq(longint'(-666) * yh);
    endfunction

    task automatic push(input int c, input int v);
        in_data[c][in_cnt[c]] = v;
        in_cnt[c]++;
    endtask

    task automatic wait_wr(input int target);
        int n;
        n = 0;
        while (wr_total < target && n < 300) begin
            @(posedge clock); #1;
            n++;
        end
        if (wr_total < target) check("timeout_wr", wr_total, target);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0;
    endtask

    // FIFO models and scoreboard: sample at negedge, apply pops just after posedge.
    initial begin : monitor
        exp_t          e;
        logic [CH-1:0] pop_req;
        x_in       = '0;
        x_in_empty = '1;
        pop_req    = '0;
        forever begin
            @(negedge clock);
            cyc++;
            if (reset) begin
                for (int c = 0; c < CH; c++) begin
                    mxh[c] = 0;
                    myh[c] = 0;
                end
                exp_q.delete();
            end else begin
                if (x_in_rd_en != '0 || y_out_wr_en != '0)
                    check("strobe_onehot", $countones({x_in_rd_en, y_out_wr_en}), 1);
                for (int c = 0; c < CH; c++) begin
                    if (x_in_rd_en[c]) begin
                        check("rd_nonempty", int'(in_rd[c] < in_cnt[c]), 1);
                        e.ch  = c;
                        e.x   = in_data[c][in_rd[c]];
                        e.y   = model_y(e.x, mxh[c], myh[c]);
                        e.cyc = cyc;
                        exp_q.push_back(e);
                        pop_req[c] = 1'b1;
                        rd_total++;
                        rd_ch_cnt[c]++;
                    end
                end
                for (int c = 0; c < CH; c++) begin
                    if (y_out_wr_en[c]) begin
                        if (exp_q.size() == 0) begin
                            check("wr_unexpected", c, -1);
                        end else begin
                            e = exp_q.pop_front();
                            check("wr_ch", c, e.ch);
                            check("wr_y", y_out[c*DW +: DW], e.y);
                            check("wr_latency", cyc - e.cyc, 4);
                            mxh[e.ch] = e.x;
                            myh[e.ch] = e.y;
                        end
                        log_ch[wr_total] = c;
                        log_y[wr_total]  = y_out[c*DW +: DW];
                        wr_total++;
                    end
                end
                if (clear && !busy) begin
                    for (int c = 0; c < CH; c++) begin
                        mxh[c] = 0;
                        myh[c] = 0;
                    end
                end
            end
            @(posedge clock); #1;
            for (int c = 0; c < CH; c++) begin
                if (pop_req[c]) in_rd[c]++;
                x_in_empty[c] = (in_rd[c] >= in_cnt[c]);
                x_in[c*DW +: DW] = x_in_empty[c] ? '0 : in_data[c][in_rd[c]];
            end
            pop_req = '0;
        end
    end

    initial begin : main
        int base;
        int found;
        y_out_full = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_rd_en", int'(x_in_rd_en), 0);
        check("rst_wr_en", int'(y_out_wr_en), 0);
        check("rst_y_out_nz", int'(y_out != '0), 0);
        check("rst_busy", int'(busy), 0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Single-lane impulse then repeat on built-up history.
        push(0, 1024);
        push(0, 1024);
        wait_wr(2);
        check("step_y0", log_y[0], 178);
        check("step_y1", log_y[1], 241);

        pulse_clear();
        push(0, 1024);
        wait_wr(3);
        check("clear_pulse_y", log_y[2], 178);

        pulse_clear();
        push(0, -1);
        wait_wr(4);
        check("neg_round_y", log_y[3], 0);

        // Clear held high must block every read.
        clear = 1'b1;
        push(0, 1024);
        base = rd_total;
        repeat (20) begin
            @(posedge clock); #1;
        end
        check("clear_hold_rd", rd_total, base);
        clear = 1'b0;
        wait_wr(5);
        check("clear_hold_y", log_y[4], 178);

        // Serve ch1 once so the pointer returns to ch0, then fill both lanes.
        push(1, 555);
        wait_wr(6);
        check("ch1_only_ch", log_ch[5], 1);
        check("ch1_only_y", log_y[5], 96);
        for (int k = 0; k < 3; k++) begin
            push(0, int'($urandom));
            push(1, int'($urandom_range(0, 200000)) - 100000);
        end
        wait_wr(12);
        for (int k = 0; k < 6; k++) check("rr_order", log_ch[6 + k], k % 2);

        // Full output lane is skipped until it drains.
        y_out_full = 2'b10;
        base = rd_ch_cnt[1];
        push(0, 3000);
        push(0, -7000);
        push(1, 12345);
        wait_wr(14);
        check("full_rd_blocked", rd_ch_cnt[1], base);
        check("full_ch_a", log_ch[12], 0);
        check("full_ch_b", log_ch[13], 0);
        y_out_full = 2'b00;
        wait_wr(15);
        check("full_release_ch", log_ch[14], 1);

        // Reset in MUL1 aborts the sample and wipes history.
        push(0, 777);
        found = 0;
        for (int n = 0; n < 50 && found == 0; n++) begin
            if (x_in_rd_en[0]) found = 1;
            else begin
                @(posedge clock); #1;
            end
        end
        check("mid_rst_rd_seen", found, 1);
        @(posedge clock); #1;
        @(posedge clock); #1;
        base = wr_total;
        reset = 1'b1;
        #1;
        check("mid_rst_rd_en", int'(x_in_rd_en), 0);
        check("mid_rst_wr_en", int'(y_out_wr_en), 0);
        check("mid_rst_y_nz", int'(y_out != '0), 0);
        check("mid_rst_busy", int'(busy), 0);
        repeat (3) @(posedge clock);
        #1;
        check("mid_rst_no_wr", wr_total, base);
        reset = 1'b0;
        @(posedge clock); #1;
        push(0, 1024);
        wait_wr(base + 1);
        check("post_rst_y", log_y[base], 178);
        check("post_rst_ch", log_ch[base], 0);

        repeat (5) @(posedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
